// File: rtl/bird_motion.sv
// bird_motion: vertical physics and start/pause flow for the bird.
// Each frame tick that the bird FSM allows applies gravity or a flap
// impulse and then moves the bird. A hit on the top or bottom edge is
// sticky and freezes the bird. A small wait FSM handles start-on-flap and
// the pause toggle for the bird FSM.
module bird_motion #(
  parameter int POS_W   = 10,
  parameter int VEL_W   = 6,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 479,
  parameter int Y_START = 240,
  parameter int BIRD_H  = 16,
  parameter int GRAVITY = 1,
  parameter int FLAP_V  = 8,
  parameter int V_MAX   = 8
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iFrameTick,
  input  logic                    iPosRst,
  input  logic                    iMove,
  input  logic                    iFlap,
  input  logic                    iPause,
  output logic                    oBirdWait,
  output logic                    oBirdHit,
  output logic [POS_W-1:0]        oBirdY,
  output logic signed [VEL_W-1:0] oBirdVel
);

  // Wide enough for position plus any velocity, with sign, without wrap.
  localparam int YW = POS_W + 2;
  // Wide enough for velocity plus gravity without wrap.
  localparam int VW = VEL_W + 2;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_RUN   = 2'd1,
    W_PAUSE = 2'd2
  } wait_state_t;

  // Next velocity: flap impulse, or gravity limited to the terminal speed.
  function automatic logic signed [VEL_W-1:0] f_vel_next(
    input logic signed [VEL_W-1:0] v,
    input logic                    flap
  );
    logic signed [VW-1:0] s;
    s = VW'(v) + VW'(GRAVITY);
    if (flap)
      return VEL_W'(-FLAP_V);
    else if (s > VW'(V_MAX))
      return VEL_W'(V_MAX);
    else
      return s[VEL_W-1:0];
  endfunction

  // Signed candidate position so moves above row 0 stay visible as <= 0.
  function automatic logic signed [YW-1:0] f_y_sum(
    input logic [POS_W-1:0]        y,
    input logic signed [VEL_W-1:0] v
  );
    return $signed({2'b00, y}) + YW'(v);
  endfunction

  // Clamp the candidate onto the screen; the bird keeps its full height.
  function automatic logic [POS_W-1:0] f_y_clamp(
    input logic signed [YW-1:0] yn,
    input logic                 top,
    input logic                 bot
  );
    if (top)
      return POS_W'(Y_MIN);
    else if (bot)
      return POS_W'(Y_MAX - BIRD_H + 1);
    else
      return yn[POS_W-1:0];
  endfunction

  logic                    r_flap_d;
  logic                    r_pause_d;
  logic                    r_pend;
  logic                    r_hit;
  logic                    r_wait;
  logic [POS_W-1:0]        r_y;
  logic signed [VEL_W-1:0] r_vel;
  wait_state_t             r_state;

  logic                    w_flap_ev;
  logic                    w_pause_ev;
  logic                    w_upd;
  logic                    w_flap_use;
  logic signed [VEL_W-1:0] w_vnew;
  logic signed [YW-1:0]    w_ynext;
  logic                    w_hit_top;
  logic                    w_hit_bot;
  logic [POS_W-1:0]        w_ypos;
  wait_state_t             w_state_nxt;

  assign w_flap_ev  = iFlap & ~r_flap_d;
  assign w_pause_ev = iPause & ~r_pause_d;
  assign w_upd      = iFrameTick & iMove & ~r_hit;
  // A flap edge on the same cycle as the tick counts for that tick.
  assign w_flap_use = r_pend | w_flap_ev;
  assign w_vnew     = f_vel_next(r_vel, w_flap_use);
  assign w_ynext    = f_y_sum(r_y, w_vnew);
  assign w_hit_top  = (w_ynext <= YW'(Y_MIN));
  assign w_hit_bot  = ((w_ynext + YW'(BIRD_H - 1)) >= YW'(Y_MAX));
  assign w_ypos     = f_y_clamp(w_ynext, w_hit_top, w_hit_bot);

  assign oBirdWait = r_wait;
  assign oBirdHit  = r_hit;
  assign oBirdY    = r_y;
  assign oBirdVel  = r_vel;

  // Button delay registers for rising-edge detection.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_flap_d  <= 1'b0;
      r_pause_d <= 1'b0;
    end else begin
      r_flap_d  <= iFlap;
      r_pause_d <= iPause;
    end
  end

  // Wait FSM state register with registered wait output.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= W_IDLE;
      r_wait  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= (w_state_nxt != W_RUN);
    end
  end

  // Wait FSM next state: flap starts the game, pause edges toggle pause.
  always_comb begin
    w_state_nxt = r_state;
    if (iPosRst) begin
      w_state_nxt = W_IDLE;
    end else begin
      case (r_state)
        W_IDLE:  if (w_flap_ev)  w_state_nxt = W_RUN;
        W_RUN:   if (w_pause_ev) w_state_nxt = W_PAUSE;
        W_PAUSE: if (w_pause_ev) w_state_nxt = W_RUN;
        default: w_state_nxt = W_IDLE;
      endcase
    end
  end

  // Flap-pending flag: remembers a flap until a physics update consumes it.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      r_pend <= 1'b0;
    else if (iPosRst)
      r_pend <= 1'b0;
    else if (w_upd)
      r_pend <= 1'b0;
    else if (w_flap_ev)
      r_pend <= 1'b1;
  end

  // Per-frame physics update with sticky collision.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_y   <= POS_W'(Y_START);
      r_vel <= '0;
      r_hit <= 1'b0;
    end else if (iPosRst) begin
      r_y   <= POS_W'(Y_START);
      r_vel <= '0;
      r_hit <= 1'b0;
    end else if (w_upd) begin
      r_y   <= w_ypos;
      r_vel <= w_vnew;
      r_hit <= w_hit_top | w_hit_bot;
    end
  end

endmodule
